// File: rtl/seg7_rx_pkg.sv
// Shared definitions for the 7-segment code receiver: code width, FSM states,
// stop-bit level and the odd-parity helper used by the optional parity output.
package seg7_rx_pkg;

  localparam int CODE_W = 6;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Odd parity is required, so an even number of ones is an error.
  function automatic logic odd_parity_err(input logic [CODE_W-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/seg7_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to
// the idle level (1) so reset never looks like a start bit.
module seg7_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/seg7_code_receiver.sv
// Serial receiver for 6-bit 7-segment codes (start, 6 bits LSB first, stop).
// Define SEG7_RX_PARITY_CHECK_EN to add the registered parity_err output.
module seg7_code_receiver
  import seg7_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              frame_err,
  output logic              busy
`ifdef SEG7_RX_PARITY_CHECK_EN
  ,
  output logic              parity_err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(CODE_W - 1);

  logic              rx_s;
  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [2:0]        bit_idx_r, bit_idx_nxt_s;
  logic [CODE_W-1:0] shift_r, shift_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic              code_valid_r, code_valid_nxt_s;
  logic              frame_err_r, frame_err_nxt_s;
  logic              busy_r;
  // Set after a bad stop bit: the line must return high before a new start.
  logic              wait_high_r, wait_high_nxt_s;
`ifdef SEG7_RX_PARITY_CHECK_EN
  logic              parity_err_r, parity_err_nxt_s;
`endif

  seg7_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Next-state, sampling and output-pulse logic.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    bit_idx_nxt_s    = bit_idx_r;
    shift_nxt_s      = shift_r;
    code_nxt_s       = code_r;
    code_valid_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;
    wait_high_nxt_s  = wait_high_r;
`ifdef SEG7_RX_PARITY_CHECK_EN
    parity_err_nxt_s = parity_err_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_nxt_s     = {CNT_W{1'b0}};
        bit_idx_nxt_s = 3'd0;
        if (wait_high_r) begin
          if (rx_s == 1'b1) begin
            wait_high_nxt_s = 1'b0;
          end else begin
            wait_high_nxt_s = 1'b1;
          end
        end else if (rx_s == 1'b0) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (rx_s == 1'b0) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          shift_nxt_s = {rx_s, shift_r[CODE_W-1:1]};
          if (bit_idx_r == IDX_LAST) begin
            bit_idx_nxt_s = 3'd0;
            state_nxt_s   = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = IDLE;
          if (rx_s == STOP_BIT) begin
            code_nxt_s       = shift_r;
            code_valid_nxt_s = 1'b1;
`ifdef SEG7_RX_PARITY_CHECK_EN
            parity_err_nxt_s = odd_parity_err(shift_r);
`endif
          end else begin
            frame_err_nxt_s = 1'b1;
            wait_high_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        cnt_nxt_s     = {CNT_W{1'b0}};
        bit_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= {CODE_W{1'b0}};
      code_r       <= {CODE_W{1'b0}};
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
      wait_high_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      bit_idx_r    <= bit_idx_nxt_s;
      shift_r      <= shift_nxt_s;
      code_r       <= code_nxt_s;
      code_valid_r <= code_valid_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      wait_high_r  <= wait_high_nxt_s;
    end
  end

`ifdef SEG7_RX_PARITY_CHECK_EN
  // Parity flag register, loaded together with code.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= parity_err_nxt_s;
    end
  end

  assign parity_err = parity_err_r;
`endif

  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign frame_err  = frame_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_seg7_code_receiver.sv
// Directed, table-driven bench for seg7_code_receiver at CLKS_PER_BIT=4.
module tb_seg7_code_receiver;

  localparam int CPB = 4;
  localparam int FRAME_BUSY = CPB / 2 + 6 * CPB + CPB;

  typedef struct packed {
    logic [5:0] data;
    logic       stop;
    logic [5:0] exp_code;
    logic       exp_valid;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [5:0] code;
  logic       code_valid;
  logic       frame_err;
  logic       busy;
`ifdef SEG7_RX_PARITY_CHECK_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int nf = 0;
  int nboth = 0;
  int nbusy = 0;
  int nbad = 0;
  logic [5:0] prev_code = 6'd0;
  logic [5:0] vq[$];

  always #5 clk = ~clk;

  seg7_code_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef SEG7_RX_PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  // Pulse, busy and code-stability monitor.
  always @(negedge clk) begin
    if (code_valid) begin
      nv <= nv + 1;
      vq.push_back(code);
    end
    if (frame_err) nf <= nf + 1;
    if (code_valid && frame_err) nboth <= nboth + 1;
    if (busy) nbusy <= nbusy + 1;
    if ((code !== prev_code) && !code_valid && !rst) nbad <= nbad + 1;
    prev_code <= code;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [5:0] c, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rx = c[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs[6];
  int v0, f0, b0, bz0, bad0, q0;
  logic par_model;

  initial begin
    vecs[0] = '{data: 6'b000101, stop: 1'b1, exp_code: 6'b000101, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 6'b111111, stop: 1'b1, exp_code: 6'b111111, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 6'b100000, stop: 1'b1, exp_code: 6'b100000, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 6'b101010, stop: 1'b0, exp_code: 6'b100000, exp_valid: 1'b0, exp_err: 1'b1};
    vecs[4] = '{data: 6'b010101, stop: 1'b1, exp_code: 6'b010101, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[5] = '{data: 6'b110011, stop: 1'b1, exp_code: 6'b110011, exp_valid: 1'b1, exp_err: 1'b0};
    par_model = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
`ifdef SEG7_RX_PARITY_CHECK_EN
    check("rst_parity", int'(parity_err), 0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven single frames.
    for (int k = 0; k < 6; k++) begin
      v0 = nv; f0 = nf; b0 = nboth; bz0 = nbusy; bad0 = nbad;
      send_frame(vecs[k].data, vecs[k].stop);
      settle();
      check($sformatf("v%0d_valid", k), nv - v0, int'(vecs[k].exp_valid));
      check($sformatf("v%0d_ferr", k), nf - f0, int'(vecs[k].exp_err));
      check($sformatf("v%0d_code", k), int'(code), int'(vecs[k].exp_code));
      check($sformatf("v%0d_busy_end", k), int'(busy), 0);
      check($sformatf("v%0d_busy_len", k), nbusy - bz0, FRAME_BUSY);
      check($sformatf("v%0d_both", k), nboth - b0, 0);
      check($sformatf("v%0d_stable", k), nbad - bad0, 0);
`ifdef SEG7_RX_PARITY_CHECK_EN
      if (vecs[k].exp_valid) par_model = ~(^vecs[k].exp_code);
      check($sformatf("v%0d_parity", k), int'(parity_err), int'(par_model));
`endif
    end

    // Back-to-back frames.
    v0 = nv; f0 = nf; q0 = vq.size();
    send_frame(6'b000001, 1'b1);
    send_frame(6'b000011, 1'b1);
    settle();
    check("b2b_valid", nv - v0, 2);
    check("b2b_ferr", nf - f0, 0);
    if (vq.size() >= q0 + 2) begin
      check("b2b_first", int'(vq[q0]), 1);
      check("b2b_second", int'(vq[q0+1]), 3);
    end else begin
      check("b2b_queue", vq.size() - q0, 2);
    end
    check("b2b_code", int'(code), 3);

    // One-cycle glitch on rx.
    v0 = nv; f0 = nf; bz0 = nbusy;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    settle();
    check("glitch_valid", nv - v0, 0);
    check("glitch_ferr", nf - f0, 0);
    check("glitch_code", int'(code), 3);
    check("glitch_busy", int'(busy), 0);
    check("glitch_busy_len", nbusy - bz0, CPB / 2);

    // Reset after three data bits.
    v0 = nv; f0 = nf;
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (CPB) @(negedge clk);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_code", int'(code), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(code_valid), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_pulses", (nv - v0) + (nf - f0), 0);
    check("post_rst_busy", int'(busy), 0);
    v0 = nv;
    send_frame(6'b000011, 1'b1);
    settle();
    check("post_rst_valid", nv - v0, 1);
    check("post_rst_code", int'(code), 3);

`ifdef SEG7_RX_PARITY_CHECK_EN
    send_frame(6'b000000, 1'b1);
    settle();
    check("par_zero_code", int'(code), 0);
    check("par_zero", int'(parity_err), 1);
    send_frame(6'b000001, 1'b1);
    settle();
    check("par_one", int'(parity_err), 0);
`endif

    check("never_both", nboth, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
